// File: rtl/uart_debug_loader_pkg.sv
// Shared constants, state encodings and baud-divider helper for the UART debug loader.
package uart_debug_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StCnt,
        StData,
        StWrite,
        StCsum,
        StResp
    } state_e;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / baud;
    endfunction

    // States in which the inter-byte timeout and frame-error tracking apply.
    function automatic logic in_frame(input state_e st);
        return st inside {StAddr, StCnt, StData, StWrite, StCsum};
    endfunction

endpackage

// File: rtl/uart_debug_loader_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, glitch-filtered start, stop check.
module uart_rx_byte
    import uart_debug_loader_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    input  logic       i_abort,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err
);

    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_END = CW'(BAUD_DIV - 1);

    rx_state_e     r_state;
    logic          r_s1;
    logic          r_s2;
    logic          r_prev;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_ferr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RxIdle;
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_prev  <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_s1    <= i_rx;
            r_s2    <= r_s1;
            r_prev  <= r_s2;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            if (i_abort) begin
                r_state <= RxIdle;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    RxIdle: begin
                        if (r_prev && !r_s2) begin
                            r_state <= RxStart;
                            r_cnt   <= '0;
                        end
                    end
                    RxStart: begin
                        if (r_cnt == HALF_END) begin
                            r_cnt   <= '0;
                            r_bit   <= '0;
                            // A start bit that is high again at mid-bit was a glitch.
                            r_state <= r_s2 ? RxIdle : RxData;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    RxData: begin
                        if (r_cnt == FULL_END) begin
                            r_cnt  <= '0;
                            r_data <= {r_s2, r_data[7:1]};
                            r_bit  <= r_bit + 3'd1;
                            if (r_bit == 3'd7) begin
                                r_state <= RxStop;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    RxStop: begin
                        if (r_cnt == FULL_END) begin
                            r_cnt   <= '0;
                            r_state <= RxIdle;
                            if (r_s2) begin
                                r_valid <= 1'b1;
                            end else begin
                                r_ferr <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign o_byte_valid = r_valid;
    assign o_byte_data  = r_data;
    assign o_frame_err  = r_ferr;

endmodule

// File: rtl/uart_debug_loader.sv
// UART-fed bus master: parses A5-framed images, writes one word per cycle, answers ACK/NAK.
module uart_debug_loader
    import uart_debug_loader_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 50000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        debug_en_i,
    input  logic        rx_pin,
    output logic        tx_pin,
    output logic        req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o
);

    localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_END = CW'(BAUD_DIV - 1);
    localparam logic [31:0] TIMEOUT_END = 32'(TIMEOUT_CYC - 1);

    state_e        r_state;
    logic          r_en_s1;
    logic          r_en_s2;
    logic [1:0]    r_byte_cnt;
    logic [8:0]    r_word_cnt;
    logic [7:0]    r_csum;
    logic          r_ferr;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_idle_cnt;
    logic          r_req;
    logic          r_busy;
    logic          r_tx;
    logic [8:0]    r_tx_frame;
    logic [3:0]    r_tx_idx;
    logic [CW-1:0] r_tx_cnt;

    logic          w_rx_valid;
    logic          w_rx_ferr;
    logic [7:0]    w_rx_data;
    logic          w_rx_abort;
    logic          w_timeout;
    logic          w_unused_rdata;

    assign w_unused_rdata = ^mem_rdata_i;
    assign w_rx_abort     = ~r_en_s2;
    assign w_timeout      = in_frame(r_state) && !w_rx_valid && (r_idle_cnt == TIMEOUT_END);

    uart_rx_byte #(
        .BAUD_DIV(BAUD_DIV)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rx        (rx_pin),
        .i_abort     (w_rx_abort),
        .o_byte_valid(w_rx_valid),
        .o_byte_data (w_rx_data),
        .o_frame_err (w_rx_ferr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_en_s1    <= 1'b0;
            r_en_s2    <= 1'b0;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_csum     <= '0;
            r_ferr     <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_idle_cnt <= '0;
            r_req      <= 1'b0;
            r_busy     <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_frame <= '1;
            r_tx_idx   <= '0;
            r_tx_cnt   <= '0;
        end else begin
            r_en_s1 <= debug_en_i;
            r_en_s2 <= r_en_s1;
            if (!r_en_s2) begin
                r_state <= StIdle;
                r_req   <= 1'b0;
                r_tx    <= 1'b1;
                r_busy  <= 1'b0;
            end else if (w_timeout) begin
                r_state    <= StIdle;
                r_req      <= 1'b0;
                r_busy     <= 1'b0;
                r_idle_cnt <= '0;
            end else begin
                if (in_frame(r_state)) begin
                    r_idle_cnt <= w_rx_valid ? 32'd0 : r_idle_cnt + 32'd1;
                    if (w_rx_ferr) begin
                        r_ferr <= 1'b1;
                    end
                end
                case (r_state)
                    StIdle: begin
                        if (w_rx_valid && w_rx_data == SYNC_BYTE) begin
                            r_state    <= StAddr;
                            r_busy     <= 1'b1;
                            r_byte_cnt <= '0;
                            r_csum     <= '0;
                            r_ferr     <= 1'b0;
                            r_idle_cnt <= '0;
                        end
                    end
                    StAddr: begin
                        if (w_rx_valid) begin
                            r_csum     <= r_csum ^ w_rx_data;
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            if (r_byte_cnt == 2'd3) begin
                                r_addr  <= {w_rx_data, r_addr[31:10], 2'b00};
                                r_state <= StCnt;
                            end else begin
                                r_addr <= {w_rx_data, r_addr[31:8]};
                            end
                        end
                    end
                    StCnt: begin
                        if (w_rx_valid) begin
                            r_csum     <= r_csum ^ w_rx_data;
                            r_word_cnt <= {(w_rx_data == 8'h00), w_rx_data};
                            r_byte_cnt <= '0;
                            r_state    <= StData;
                        end
                    end
                    StData: begin
                        if (w_rx_valid) begin
                            r_csum     <= r_csum ^ w_rx_data;
                            r_wdata    <= {w_rx_data, r_wdata[31:8]};
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            if (r_byte_cnt == 2'd3) begin
                                r_req   <= 1'b1;
                                r_state <= StWrite;
                            end
                        end
                    end
                    StWrite: begin
                        r_req      <= 1'b0;
                        r_addr     <= r_addr + 32'd4;
                        r_word_cnt <= r_word_cnt - 9'd1;
                        r_state    <= (r_word_cnt == 9'd1) ? StCsum : StData;
                    end
                    StCsum: begin
                        if (w_rx_valid) begin
                            r_tx_frame <= {1'b1, (w_rx_data == r_csum && !r_ferr) ?
                                                 ACK_BYTE : NAK_BYTE};
                            r_tx       <= 1'b0;
                            r_tx_idx   <= '0;
                            r_tx_cnt   <= '0;
                            r_state    <= StResp;
                        end
                    end
                    StResp: begin
                        if (r_tx_cnt == BIT_END) begin
                            r_tx_cnt <= '0;
                            // Index 9 means the stop bit has now been held a full bit time.
                            if (r_tx_idx == 4'd9) begin
                                r_state <= StIdle;
                                r_busy  <= 1'b0;
                            end else begin
                                r_tx       <= r_tx_frame[0];
                                r_tx_frame <= {1'b1, r_tx_frame[8:1]};
                                r_tx_idx   <= r_tx_idx + 4'd1;
                            end
                        end else begin
                            r_tx_cnt <= r_tx_cnt + CW'(1);
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_req   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx_pin      = r_tx;
    assign req_o       = r_req;
    assign mem_we_o    = r_req;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign busy_o      = r_busy;

endmodule
